updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised modulo up/down counter, the next generation of the team's fixed 4-bit up counter. It adds configurable width and modulus, direction control, count enable, parallel load, terminal-count and wrap indications, and an optional saturating mode. It is the timebase and event-count primitive for the timer, divider and sequencing blocks in the design.

## Interface
- WIDTH, 8: counter width in bits, legal range 2..32.
- MAX, 2**WIDTH-1: highest count value, so the modulus is MAX+1. Legal range 1..2**WIDTH-1.
- RESET_VAL, 0: count value after reset. Must be ≤ MAX.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  reset, synchronous, active-high.
- en  in  1  count enable; when high, the counter steps one position per cycle.
- up  in  1  direction: 1 counts up, 0 counts down.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- sat  in  1  saturate select. The port exists only when COUNTER_SAT_EN is defined.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational from count and up.
- wrap  out  1  one-cycle registered pulse after a wrap transition.

## Operation
- Priority on each rising clk edge, highest first: reset, then load, then en, then hold.
- reset=1: count←RESET_VAL, wrap←0. All other inputs are ignored. Reset in the middle of a count takes effect on that same edge.
- load=1: count←load_val when load_val ≤ MAX; otherwise count←MAX (clamped). wrap←0. en and up are ignored on that edge.
- en=1, up=1:
  - If count<MAX: count←count+1.
  - If count==MAX: count←0 and wrap←1.
- en=1, up=0:
  - If count>0: count←count-1.
  - If count==0: count←MAX and wrap←1.
- en=0 (and no load): count holds its value.
- wrap is 0 on every edge that does not perform a wrap transition, so it is never high for more than one cycle per wrap.
- tc = (up && count==MAX) || (!up && count==0). tc does not depend on en and is not registered.
- Arithmetic is modulo MAX+1, never modulo 2**WIDTH. count never exceeds MAX.
- Changing up between cycles takes effect on the next enabled edge. There is no hysteresis.

## Timing
- Latency from an input to count is 1 cycle (load, step or reset).
- wrap goes high in the same cycle that count shows the wrapped value (0 or MAX).
- tc follows up combinationally within the same cycle. A consumer that needs a glitch-free signal must register tc.
- Throughput: one step per cycle when en is held high.
- No handshake. load and en are level-sampled on every edge.

## Configuration
- COUNTER_SAT_EN defined:
  - The sat port exists.
  - With sat=1, an enabled step at the boundary (up at MAX, down at 0) holds count and keeps wrap at 0.
  - With sat=0, the counter wraps as described in Operation.
  - tc behaves the same in both modes.
- COUNTER_SAT_EN undefined: the sat port and the saturating logic are absent, and the counter always wraps.

## Test plan
- WIDTH=4, MAX=9, RESET_VAL=0. Hold reset for 2 cycles, then en=1, up=1 for 12 cycles → count runs 0,1,…,9,0,1,2. wrap is high only in the cycle count=0 after 9. tc is high while count=9.
- Same configuration, load=1 with load_val=3, then en=1, up=0 for 5 cycles → count runs 3,2,1,0,9,8. wrap is high with the first 9. tc is high while count=0.
- load_val=4'hF (greater than MAX=9) → count=9 the next cycle and wrap=0. load=1 together with en=1 → the load wins.
- Counting with en=1 and count=6, assert reset for 1 cycle → count=0 and wrap=0 the next cycle. Counting resumes from 0 after release.
- en toggled 1,0,0,1 while up=1 from count=2 → count sequence 3,3,3,4. Switching up from 1 to 0 at count=5 → next value 4.
- COUNTER_SAT_EN defined, sat=1, up=1 from count=8 for 4 cycles → 9,9,9,9 with wrap=0 throughout. sat=1, up=0 from count=0 → count stays 0.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Parametrised modulo up/down counter with load, terminal count and wrap pulse.
// Define COUNTER_SAT_EN to add the sat_i port and saturating boundary behaviour.
module updown_mod_counter #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX       = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
`ifdef COUNTER_SAT_EN
  input  logic             sat_i,
`endif
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             atMax, atZero, satHold;

  assign atMax  = (count_q == MAX);
  assign atZero = (count_q == '0);

`ifdef COUNTER_SAT_EN
  assign satHold = sat_i;
`else
  assign satHold = 1'b0;
`endif

  // Boundary steps wrap modulo MAX+1 unless saturation holds the count in place.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      count_d = (load_val_i > MAX) ? MAX : load_val_i;
    end else if (en_i) begin
      if (up_i) begin
        if (!atMax) begin
          count_d = count_q + 1'b1;
        end else if (!satHold) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!atZero) begin
          count_d = count_q - 1'b1;
        end else if (!satHold) begin
          count_d = MAX;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;
  assign tc_o    = (up_i && atMax) || (!up_i && atZero);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed self-checking bench for updown_mod_counter at WIDTH=4, MAX=9.
// Saturation steps are exercised only when COUNTER_SAT_EN is defined.
module tb_updown_mod_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] loadVal;
  logic       sat;
  logic [3:0] count;
  logic       tc;
  logic       wrap;

  int vectors;
  int miscompares;

  updown_mod_counter #(
    .WIDTH    (4),
    .MAX      (4'd9),
    .RESET_VAL(4'd0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en_i      (en),
    .up_i      (up),
    .load_i    (load),
    .load_val_i(loadVal),
`ifdef COUNTER_SAT_EN
    .sat_i     (sat),
`endif
    .count_o   (count),
    .tc_o      (tc),
    .wrap_o    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, clock one rising edge, then settle 1 time unit past it.
  task automatic applyStimulus(input logic r, input logic e, input logic u,
                               input logic l, input logic [3:0] lv);
    reset   = r;
    en      = e;
    up      = u;
    load    = l;
    loadVal = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expCount,
                             input logic expTc, input logic expWrap);
    vectors++;
    assert (count === expCount) else begin
      miscompares++;
      $error("[TB] FAIL %s count: observed %0d expected %0d", tag, count, expCount);
    end
    vectors++;
    assert (tc === expTc) else begin
      miscompares++;
      $error("[TB] FAIL %s tc: observed %b expected %b", tag, tc, expTc);
    end
    vectors++;
    assert (wrap === expWrap) else begin
      miscompares++;
      $error("[TB] FAIL %s wrap: observed %b expected %b", tag, wrap, expWrap);
    end
  endtask

  initial begin
    int upSeq[12];
    int dnSeq[5];
    upSeq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    dnSeq = '{2, 1, 0, 9, 8};
    vectors     = 0;
    miscompares = 0;
    sat         = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("reset", 4'd0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      checkOutput($sformatf("up%0d", i), 4'(upSeq[i]), (upSeq[i] == 9), (i == 9));
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
    checkOutput("load3", 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      checkOutput($sformatf("dn%0d", i), 4'(dnSeq[i]), (dnSeq[i] == 0), (i == 3));
    end

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
    checkOutput("loadClamp", 4'd9, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
    checkOutput("loadBeatsEn", 4'd5, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("step6", 4'd6, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("midReset", 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("resume", 4'd1, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
    checkOutput("load9", 4'd9, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("resetAtMax", 4'd0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd2);
    checkOutput("load2", 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("enA", 4'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("enB", 4'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("enC", 4'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("enD", 4'd4, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
    checkOutput("load5", 4'd5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("dirSwitch", 4'd4, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    checkOutput("load0", 4'd0, 1'b1, 1'b0);
    up = 1'b1;
    #1;
    checkOutput("tcComb", 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("hold0", 4'd0, 1'b1, 1'b0);

`ifdef COUNTER_SAT_EN
    sat = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd8);
    checkOutput("satLoad8", 4'd8, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      checkOutput($sformatf("satUp%0d", i), 4'd9, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    checkOutput("satLoad0", 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("satDn", 4'd0, 1'b1, 1'b0);
    sat = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("noSatDn", 4'd9, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
